// File: rtl/sdram_burst_sched.sv
// Burst scheduler for the shared SDRAM: arbitrates refresh, VGA reads and frame writes,
// issuing one registered burst command at a time with linear frame addresses.
module sdram_burst_sched #(
   parameter int DATA_DEPTH    = 1024*768,
   parameter int BURST_LEN     = 256,
   parameter int ADDR_W        = 24,
   parameter int LVL_W         = 10,
   parameter int REFRESH_CYC   = 780,
   parameter int MAX_RD_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_frame_start,
   input  logic              rd_frame_start,
   input  logic [LVL_W-1:0]  wr_level,
   input  logic [LVL_W-1:0]  rd_space,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [1:0]        cmd_op,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [LVL_W-1:0]  cmd_len,
   input  logic              cmd_done,
   output logic              wr_frame_done,
   output logic              rd_wrap,
   output logic              busy
);

   localparam int REF_W = $clog2(REFRESH_CYC + 1);
   localparam int STK_W = $clog2(MAX_RD_STREAK + 1);
   localparam logic [ADDR_W:0] DEPTH_X    = (ADDR_W+1)'(DATA_DEPTH);
   localparam logic [ADDR_W:0] BURST_X    = (ADDR_W+1)'(BURST_LEN);
   localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_CYC - 1);
   localparam logic [STK_W-1:0] STK_MAX    = STK_W'(MAX_RD_STREAK);
   localparam logic [1:0] OP_NONE = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_REF = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  wr_addr_reg, rd_addr_reg;
   logic               wr_en_reg, rd_en_reg;
   logic               wr_start_pend_reg, rd_start_pend_reg;
   logic [REF_W-1:0]   ref_cnt_reg;
   logic               ref_pend_reg;
   logic [STK_W-1:0]   rd_streak_reg;
   logic               cmd_valid_reg, wr_frame_done_reg, rd_wrap_reg;
   logic [1:0]         cmd_op_reg;
   logic [ADDR_W-1:0]  cmd_addr_reg;
   logic [LVL_W-1:0]   cmd_len_reg;

   logic [LVL_W-1:0]   wr_len, rd_len, grant_len;
   logic               wr_ok, rd_ok, accept, done_now, commit_wrap;
   logic [1:0]         grant_op;
   logic [ADDR_W-1:0]  grant_addr;
   logic [ADDR_W:0]    commit_end;

   // Tail burst shrinks to whatever is left of the frame.
   function automatic logic [LVL_W-1:0] burst_len(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] rem;
      logic [ADDR_W:0] len;
      rem = DEPTH_X - {1'b0, addr};
      len = (rem < BURST_X) ? rem : BURST_X;
      return LVL_W'(len);
   endfunction

   assign wr_len      = burst_len(wr_addr_reg);
   assign rd_len      = burst_len(rd_addr_reg);
   assign wr_ok       = wr_en_reg && (wr_level >= wr_len);
   assign rd_ok       = rd_en_reg && (rd_space >= rd_len);
   assign accept      = (state_reg == ISSUE) && cmd_ready;
   assign done_now    = (state_reg == WAIT) && cmd_done;
   assign commit_end  = {1'b0, cmd_addr_reg} + (ADDR_W+1)'(cmd_len_reg);
   assign commit_wrap = commit_end >= DEPTH_X;

   always_comb begin
      state_next = state_reg;
      grant_op   = OP_NONE;
      grant_addr = '0;
      grant_len  = '0;
      case (state_reg)
         IDLE: begin
            // A frame start in IDLE is applied first; arbitration resumes next cycle.
            if (!(wr_frame_start || rd_frame_start)) begin
               if (ref_pend_reg) begin
                  grant_op = OP_REF;
               end else if (rd_ok && !((rd_streak_reg == STK_MAX) && wr_ok)) begin
                  grant_op   = OP_RD;
                  grant_addr = rd_addr_reg;
                  grant_len  = rd_len;
               end else if (wr_ok) begin
                  grant_op   = OP_WR;
                  grant_addr = wr_addr_reg;
                  grant_len  = wr_len;
               end
            end
            if (grant_op != OP_NONE) state_next = ISSUE;
         end
         ISSUE:   if (cmd_ready) state_next = WAIT;
         WAIT:    if (cmd_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cmd_valid_reg <= 1'b0;
         cmd_op_reg    <= OP_NONE;
         cmd_addr_reg  <= '0;
         cmd_len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (grant_op != OP_NONE) begin
            cmd_valid_reg <= 1'b1;
            cmd_op_reg    <= grant_op;
            cmd_addr_reg  <= grant_addr;
            cmd_len_reg   <= grant_len;
         end else if (accept) begin
            cmd_valid_reg <= 1'b0;
         end else if (done_now) begin
            cmd_op_reg   <= OP_NONE;
            cmd_addr_reg <= '0;
            cmd_len_reg  <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_reg       <= '0;
         rd_addr_reg       <= '0;
         wr_en_reg         <= 1'b0;
         rd_en_reg         <= 1'b0;
         wr_start_pend_reg <= 1'b0;
         rd_start_pend_reg <= 1'b0;
         rd_streak_reg     <= '0;
         wr_frame_done_reg <= 1'b0;
         rd_wrap_reg       <= 1'b0;
      end else begin
         wr_frame_done_reg <= 1'b0;
         rd_wrap_reg       <= 1'b0;
         if (state_reg == IDLE) begin
            if (wr_frame_start) begin
               wr_addr_reg <= '0;
               wr_en_reg   <= 1'b1;
            end
            if (rd_frame_start) begin
               rd_addr_reg <= '0;
               rd_en_reg   <= 1'b1;
            end
         end else if (done_now) begin
            // A frame start seen during the burst overrides this burst's address commit.
            if (wr_frame_start || wr_start_pend_reg) begin
               wr_addr_reg       <= '0;
               wr_en_reg         <= 1'b1;
               wr_start_pend_reg <= 1'b0;
            end else if (cmd_op_reg == OP_WR) begin
               if (commit_wrap) begin
                  wr_addr_reg       <= '0;
                  wr_en_reg         <= 1'b0;
                  wr_frame_done_reg <= 1'b1;
               end else begin
                  wr_addr_reg <= commit_end[ADDR_W-1:0];
               end
            end
            if (rd_frame_start || rd_start_pend_reg) begin
               rd_addr_reg       <= '0;
               rd_en_reg         <= 1'b1;
               rd_start_pend_reg <= 1'b0;
            end else if (cmd_op_reg == OP_RD) begin
               if (commit_wrap) begin
                  rd_addr_reg <= '0;
                  rd_wrap_reg <= 1'b1;
               end else begin
                  rd_addr_reg <= commit_end[ADDR_W-1:0];
               end
            end
            if (cmd_op_reg == OP_RD && rd_streak_reg != STK_MAX)
               rd_streak_reg <= rd_streak_reg + STK_W'(1);
            else if (cmd_op_reg == OP_WR)
               rd_streak_reg <= '0;
         end else begin
            if (wr_frame_start) wr_start_pend_reg <= 1'b1;
            if (rd_frame_start) rd_start_pend_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_reg  <= REF_RELOAD;
         ref_pend_reg <= 1'b0;
      end else if (ref_cnt_reg == '0) begin
         ref_cnt_reg  <= REF_RELOAD;
         ref_pend_reg <= 1'b1;
      end else begin
         ref_cnt_reg <= ref_cnt_reg - REF_W'(1);
         if (accept && cmd_op_reg == OP_REF) ref_pend_reg <= 1'b0;
      end
   end

   assign cmd_valid     = cmd_valid_reg;
   assign cmd_op        = cmd_op_reg;
   assign cmd_addr      = cmd_addr_reg;
   assign cmd_len       = cmd_len_reg;
   assign wr_frame_done = wr_frame_done_reg;
   assign rd_wrap       = rd_wrap_reg;
   assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched: vector table, directed corner sequences, and randomized
// traffic checked against a transaction-level model of the scheduling rules.
module tb_sdram_burst_sched;
   localparam int DEPTH = 600, BURST = 256, AW = 24, LW = 10, REFC = 780, MAXS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, wr_frame_start, rd_frame_start, cmd_ready, cmd_done;
   logic [LW-1:0] wr_level, rd_space, cmd_len;
   logic          cmd_valid, wr_frame_done, rd_wrap, busy;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;

   int n_cmp = 0, n_fail = 0;

   sdram_burst_sched #(
      .DATA_DEPTH(DEPTH), .BURST_LEN(BURST), .ADDR_W(AW), .LVL_W(LW),
      .REFRESH_CYC(REFC), .MAX_RD_STREAK(MAXS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
      .wr_level(wr_level), .rd_space(rd_space), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done),
      .wr_frame_done(wr_frame_done), .rd_wrap(rd_wrap), .busy(busy)
   );

   typedef struct {
      bit ws; bit rs; int wl; int sp;
      int op; int addr; int len; bit fd; bit wp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0; wr_level = '0; rd_space = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Pulse frame starts with levels at zero, then apply the requested levels.
   task automatic starts(input bit ws, input bit rs, input int wl, input int sp);
      wr_level = '0; rd_space = '0;
      wr_frame_start = ws; rd_frame_start = rs;
      @(negedge clk);
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      wr_level = LW'(wl); rd_space = LW'(sp);
   endtask

   // Serve one command as the controller would; optional frame-start pulses during WAIT.
   task automatic do_cmd(input int rdy_dly, input int done_dly, input bit wpulse, input bit rpulse,
                         output int op, output int addr, output int len, output bit fd, output bit wp);
      int t;
      op = 0; addr = 0; len = 0; fd = 0; wp = 0;
      t = 0;
      while (cmd_valid !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (cmd_valid !== 1'b1) begin
         check("cmd_valid_timeout", 32'(cmd_valid), 32'd1);
         return;
      end
      check("busy_issue", 32'(busy), 32'd1);
      op = int'(cmd_op); addr = int'(cmd_addr); len = int'(cmd_len);
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(cmd_valid), 32'd1);
         check("hold_op", 32'(cmd_op), 32'(op));
         check("hold_addr", 32'(cmd_addr), 32'(addr));
         check("hold_len", 32'(cmd_len), 32'(len));
      end
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      check("valid_drop_after_accept", 32'(cmd_valid), 32'd0);
      check("busy_wait", 32'(busy), 32'd1);
      if (wpulse || rpulse) begin
         wr_frame_start = wpulse; rd_frame_start = rpulse;
         @(negedge clk);
         wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      end
      repeat (done_dly) @(negedge clk);
      cmd_done = 1'b1;
      @(negedge clk);
      cmd_done = 1'b0;
      fd = wr_frame_done; wp = rd_wrap;
      $display("txn op=%0d addr=%0d len=%0d frame_done=%0d wrap=%0d", op, addr, len, fd, wp);
   endtask

   // Same as do_cmd but skips interleaved refreshes.
   task automatic next_cmd(input int rdy_dly, input int done_dly, input bit wpulse,
                           output int op, output int addr, output int len, output bit fd, output bit wp);
      for (int k = 0; k < 3; k++) begin
         do_cmd(rdy_dly, done_dly, wpulse, 1'b0, op, addr, len, fd, wp);
         if (op != 3) break;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[19];
      int op, addr, len, t;
      bit fd, wp, seen;
      int m_wa, m_ra, m_st, wl, sp, wlen, rlen, eop;
      bit m_we, m_re, wok, rok, efd, ewp;

      // Reset state and first refresh
      rst_n = 1'b0;
      wr_frame_start = 1'b0; rd_frame_start = 1'b0;
      cmd_ready = 1'b0; cmd_done = 1'b0; wr_level = '0; rd_space = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_op", 32'(cmd_op), 32'd0);
      check("rst_addr", 32'(cmd_addr), 32'd0);
      check("rst_len", 32'(cmd_len), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(wr_frame_done), 32'd0);
      check("rst_wrap", 32'(rd_wrap), 32'd0);
      rst_n = 1'b1;
      t = 0;
      while (cmd_valid !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t < REFC || t > REFC + 2) begin
         n_fail++;
         $display("FAIL first_refresh_latency: got %0d cycles, expected %0d..%0d", t, REFC, REFC + 2);
      end
      do_cmd(0, 1, 0, 0, op, addr, len, fd, wp);
      check("first_refresh_op", 32'(op), 32'd3);
      check("first_refresh_addr", 32'(addr), 32'd0);
      check("first_refresh_len", 32'(len), 32'd0);

      // Table: write frame, read wrap, starvation rule
      tbl[0]  = '{1, 0, 300, 0,    1, 0,   256, 0, 0};
      tbl[1]  = '{0, 0, 300, 0,    1, 256, 256, 0, 0};
      tbl[2]  = '{0, 0, 300, 0,    1, 512, 88,  1, 0};
      tbl[3]  = '{0, 1, 300, 300,  2, 0,   256, 0, 0};
      tbl[4]  = '{0, 0, 300, 300,  2, 256, 256, 0, 0};
      tbl[5]  = '{0, 0, 300, 300,  2, 512, 88,  0, 1};
      tbl[6]  = '{0, 0, 300, 300,  2, 0,   256, 0, 0};
      tbl[7]  = '{1, 0, 1023, 1023, 1, 0,   256, 0, 0};
      tbl[8]  = '{0, 0, 1023, 1023, 2, 256, 256, 0, 0};
      tbl[9]  = '{0, 0, 1023, 1023, 2, 512, 88,  0, 1};
      tbl[10] = '{0, 0, 1023, 1023, 2, 0,   256, 0, 0};
      tbl[11] = '{0, 0, 1023, 1023, 2, 256, 256, 0, 0};
      tbl[12] = '{0, 0, 1023, 1023, 1, 256, 256, 0, 0};
      tbl[13] = '{0, 0, 1023, 1023, 2, 512, 88,  0, 1};
      tbl[14] = '{0, 0, 1023, 1023, 2, 0,   256, 0, 0};
      tbl[15] = '{0, 0, 1023, 1023, 2, 256, 256, 0, 0};
      tbl[16] = '{0, 0, 1023, 1023, 2, 512, 88,  0, 1};
      tbl[17] = '{0, 0, 1023, 1023, 1, 512, 88,  1, 0};
      tbl[18] = '{0, 0, 1023, 1023, 2, 0,   256, 0, 0};
      do_reset();
      for (int i = 0; i < 19; i++) begin
         if (tbl[i].ws || tbl[i].rs) starts(tbl[i].ws, tbl[i].rs, tbl[i].wl, tbl[i].sp);
         else begin
            wr_level = LW'(tbl[i].wl); rd_space = LW'(tbl[i].sp);
         end
         next_cmd(0, 2, 0, op, addr, len, fd, wp);
         check($sformatf("tbl%0d_op", i), 32'(op), 32'(tbl[i].op));
         check($sformatf("tbl%0d_addr", i), 32'(addr), 32'(tbl[i].addr));
         check($sformatf("tbl%0d_len", i), 32'(len), 32'(tbl[i].len));
         check($sformatf("tbl%0d_frame_done", i), 32'(fd), 32'(tbl[i].fd));
         check($sformatf("tbl%0d_wrap", i), 32'(wp), 32'(tbl[i].wp));
      end

      // Priority: refresh, read and write all pending when a long write completes
      do_reset();
      starts(1, 0, 1023, 1023);
      do_cmd(0, 800, 0, 1, op, addr, len, fd, wp);
      check("prio_first_write_op", 32'(op), 32'd1);
      do_cmd(5, 1, 0, 0, op, addr, len, fd, wp);
      check("prio_refresh_op", 32'(op), 32'd3);
      for (int i = 0; i < 4; i++) begin
         do_cmd(0, 1, 0, 0, op, addr, len, fd, wp);
         check($sformatf("prio_read%0d_op", i), 32'(op), 32'd2);
         check($sformatf("prio_read%0d_addr", i), 32'(addr), 32'((i * 256) % 768));
      end
      do_cmd(0, 1, 0, 0, op, addr, len, fd, wp);
      check("prio_write_op", 32'(op), 32'd1);
      check("prio_write_addr", 32'(addr), 32'd256);

      // Write frame start during WAIT restarts the frame
      do_reset();
      starts(1, 0, 1023, 0);
      next_cmd(0, 1, 0, op, addr, len, fd, wp);
      check("mid_first_addr", 32'(addr), 32'd0);
      next_cmd(0, 3, 1, op, addr, len, fd, wp);
      check("mid_second_addr", 32'(addr), 32'd256);
      check("mid_second_frame_done", 32'(fd), 32'd0);
      next_cmd(0, 1, 0, op, addr, len, fd, wp);
      check("mid_restart_op", 32'(op), 32'd1);
      check("mid_restart_addr", 32'(addr), 32'd0);
      check("mid_restart_len", 32'(len), 32'd256);

      // Asynchronous reset while a command is presented
      t = 0;
      while (cmd_valid !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("arst_reached_issue", 32'(cmd_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(cmd_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_addr", 32'(cmd_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (cmd_valid === 1'b1) seen = 1'b1;
      end
      check("arst_write_disabled", 32'(seen), 32'd0);
      starts(1, 0, 1023, 0);
      next_cmd(0, 1, 0, op, addr, len, fd, wp);
      check("arst_write_addr", 32'(addr), 32'd0);

      // Randomized traffic against the scheduling model
      do_reset();
      starts(1, 1, 0, 0);
      m_wa = 0; m_ra = 0; m_we = 1; m_re = 1; m_st = 0;
      for (int n = 0; n < 80; n++) begin
         wl = $urandom_range(0, 1023); sp = $urandom_range(0, 1023);
         wr_level = LW'(wl); rd_space = LW'(sp);
         do_cmd($urandom_range(0, 2), $urandom_range(0, 3), 0, 0, op, addr, len, fd, wp);
         efd = 0; ewp = 0;
         if (op == 3) begin
            check("rnd_ref_addr", 32'(addr), 32'd0);
            check("rnd_ref_len", 32'(len), 32'd0);
         end else begin
            wlen = (DEPTH - m_wa < BURST) ? DEPTH - m_wa : BURST;
            rlen = (DEPTH - m_ra < BURST) ? DEPTH - m_ra : BURST;
            wok = m_we && (wl >= wlen);
            rok = m_re && (sp >= rlen);
            eop = (rok && !(m_st == MAXS && wok)) ? 2 : (wok ? 1 : 0);
            check("rnd_op", 32'(op), 32'(eop));
            if (eop == 1) begin
               check("rnd_wr_addr", 32'(addr), 32'(m_wa));
               check("rnd_wr_len", 32'(len), 32'(wlen));
               m_wa += wlen; m_st = 0;
               if (m_wa == DEPTH) begin m_wa = 0; m_we = 0; efd = 1; end
            end else if (eop == 2) begin
               check("rnd_rd_addr", 32'(addr), 32'(m_ra));
               check("rnd_rd_len", 32'(len), 32'(rlen));
               m_ra += rlen;
               if (m_st < MAXS) m_st++;
               if (m_ra == DEPTH) begin m_ra = 0; ewp = 1; end
            end
         end
         check("rnd_frame_done", 32'(fd), 32'(efd));
         check("rnd_wrap", 32'(wp), 32'(ewp));
         if (!m_we && $urandom_range(0, 1) == 1) begin
            starts(1, 0, 0, 0);
            m_we = 1; m_wa = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
